bicubic_frame_streamer: RTL and testbench

//  Parametrised pixel-stream source feeding the bicubic upscaler input port. Holds one source

---
 rtl/bicubic_stream_pkg.sv | 22 ++
 rtl/bicubic_frame_mem.sv | 29 ++
 rtl/bicubic_frame_streamer.sv | 176 +++++++++++++++++
 tb/tb_bicubic_frame_streamer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_stream_pkg.sv
// Shared definitions for the bicubic input stream: pixel width, FSM encodings, clog2 helper.
package bicubic_stream_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FGAP   = 2'd2;

  function automatic int unsigned pix_width(input int unsigned ch_num, input int unsigned ch_width);
    return ch_num * ch_width;
  endfunction

  // Never returns 0 so single-entry ranges still get a 1-bit counter.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/bicubic_frame_mem.sv
// Simple dual-port frame RAM: one write port, one registered read port with hold-on-idle.
module bicubic_frame_mem #(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the stream's data register, so it holds while re is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bicubic_frame_streamer.sv
// Replays a stored frame as a valid/ready pixel stream with eol/eof flags, repeat and bubbles.
`ifndef SRC_IMG_WIDTH
`define SRC_IMG_WIDTH 960
`endif
`ifndef SRC_IMG_HEIGHT
`define SRC_IMG_HEIGHT 540
`endif
module bicubic_frame_streamer
  import bicubic_stream_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = `SRC_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = `SRC_IMG_HEIGHT,
  parameter int unsigned CH_NUM     = 3,
  parameter int unsigned CH_WIDTH   = 8,
  parameter int unsigned BOTTOM_UP  = 0,
  parameter int unsigned NUM_FRAMES = 1,
  parameter int unsigned GAP_PERIOD = 0,
  parameter int unsigned FRAME_GAP  = 0
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           ld_en,
  input  logic [clog2_min1(IMG_WIDTH*IMG_HEIGHT)-1:0]    ld_addr,
  input  logic [pix_width(CH_NUM, CH_WIDTH)-1:0]         ld_data,
  input  logic                                           start,
  input  logic                                           stop,
  input  logic                                           m_ready,
  output logic                                           m_valid,
  output logic [pix_width(CH_NUM, CH_WIDTH)-1:0]         m_data,
  output logic                                           m_eol,
  output logic                                           m_eof,
  output logic                                           busy,
  output logic                                           done,
  output logic [15:0]                                    frame_cnt
);

  localparam int unsigned PW    = pix_width(CH_NUM, CH_WIDTH);
  localparam int unsigned DEPTH = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned AW    = clog2_min1(DEPTH);
  localparam int unsigned CW    = clog2_min1(IMG_WIDTH);
  localparam int unsigned LW    = clog2_min1(IMG_HEIGHT);
  localparam logic [LW-1:0] LINE_FIRST = (BOTTOM_UP != 0) ? LW'(IMG_HEIGHT - 1) : LW'(0);
  localparam logic [LW-1:0] LINE_LAST  = (BOTTOM_UP != 0) ? LW'(0) : LW'(IMG_HEIGHT - 1);
  localparam logic [AW-1:0] BASE_FIRST =
    (BOTTOM_UP != 0) ? AW'((IMG_HEIGHT - 1) * IMG_WIDTH) : AW'(0);
  localparam logic [AW-1:0] STEP = AW'(IMG_WIDTH);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q;
  logic [LW-1:0] line_q;
  logic [AW-1:0] base_q;
  logic          more_q, stop_q, valid_q, eol_q, eof_q, done_q;
  logic [15:0]   fcnt_q;
  logic [31:0]   frames_q, beat_q, gap_q;

  logic fire, fire_eof, load, more_frames, bubble, gap_done, can_emit, emit;
  logic col_last, line_last, start_acc;

  always_comb begin
    fire        = valid_q & m_ready;
    fire_eof    = fire & eof_q;
    load        = !valid_q | m_ready;
    more_frames = !(stop_q | stop) && ((NUM_FRAMES == 0) || (frames_q + 32'd1 < NUM_FRAMES));
    bubble      = (GAP_PERIOD != 0) && fire && (beat_q == GAP_PERIOD - 1);
    gap_done    = (FRAME_GAP != 0) && (gap_q == FRAME_GAP - 1);
    col_last    = (col_q == CW'(IMG_WIDTH - 1));
    line_last   = (line_q == LINE_LAST);
    start_acc   = (state_q == ST_IDLE) && start;
    // With no frame gap the next frame's first pixel loads as the eof beat leaves.
    can_emit = ((state_q == ST_STREAM) &&
                (more_q || (fire_eof && more_frames && (FRAME_GAP == 0)))) ||
               ((state_q == ST_FGAP) && gap_done);
    emit = can_emit && load && !bubble;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_STREAM;
      ST_STREAM: if (fire_eof) begin
        if (!more_frames)        state_d = ST_IDLE;
        else if (FRAME_GAP == 0) state_d = ST_STREAM;
        else                     state_d = ST_FGAP;
      end
      ST_FGAP:   if (gap_done) state_d = ST_STREAM;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      line_q   <= '0;
      base_q   <= '0;
      more_q   <= 1'b0;
      stop_q   <= 1'b0;
      valid_q  <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      done_q   <= 1'b0;
      fcnt_q   <= '0;
      frames_q <= '0;
      beat_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= fire_eof && !more_frames;
      gap_q   <= (state_q == ST_FGAP) ? gap_q + 32'd1 : 32'd0;
      if (load) begin
        valid_q <= emit;
        eol_q   <= emit && col_last;
        eof_q   <= emit && col_last && line_last;
      end
      if (start_acc) begin
        col_q    <= '0;
        line_q   <= LINE_FIRST;
        base_q   <= BASE_FIRST;
        more_q   <= 1'b1;
        stop_q   <= 1'b0;
        fcnt_q   <= '0;
        frames_q <= '0;
        beat_q   <= '0;
      end else begin
        if ((state_q != ST_IDLE) && stop) stop_q <= 1'b1;
        if (fire) beat_q <= (fire_eof || (beat_q == GAP_PERIOD - 1)) ? 32'd0 : beat_q + 32'd1;
        if (fire_eof) begin
          frames_q <= frames_q + 32'd1;
          more_q   <= more_frames;
          if (fcnt_q != 16'hFFFF) fcnt_q <= fcnt_q + 16'd1;
        end
        if (emit) begin
          more_q <= !(col_last && line_last);
          if (!col_last) begin
            col_q <= col_q + 1'b1;
          end else begin
            col_q <= '0;
            if (line_last) begin
              line_q <= LINE_FIRST;
              base_q <= BASE_FIRST;
            end else if (BOTTOM_UP != 0) begin
              line_q <= line_q - 1'b1;
              base_q <= base_q - STEP;
            end else begin
              line_q <= line_q + 1'b1;
              base_q <= base_q + STEP;
            end
          end
        end
      end
    end
  end

  bicubic_frame_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ld_en && (state_q == ST_IDLE)),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (emit),
    .raddr (base_q + AW'(col_q)),
    .rdata (m_data)
  );

  assign m_valid   = valid_q;
  assign m_eol     = eol_q;
  assign m_eof     = eof_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_bicubic_frame_streamer.sv
// Directed bench: three 4x3 streamers (plain, bottom-up with bubbles, repeating with frame gap).
module tb_bicubic_frame_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [23:0] ld_data = '0;

  logic        start_a = 0, stop_a = 0, ready_a = 0;
  logic        valid_a, eol_a, eof_a, busy_a, done_a;
  logic [23:0] data_a;
  logic [15:0] fcnt_a;
  logic        start_b = 0, stop_b = 0, ready_b = 0;
  logic        valid_b, eol_b, eof_b, busy_b, done_b;
  logic [23:0] data_b;
  logic [15:0] fcnt_b;
  logic        start_c = 0, stop_c = 0, ready_c = 0;
  logic        valid_c, eol_c, eof_c, busy_c, done_c;
  logic [23:0] data_c;
  logic [15:0] fcnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bicubic_frame_streamer #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) u_a (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start_a), .stop(stop_a), .m_ready(ready_a), .m_valid(valid_a), .m_data(data_a),
    .m_eol(eol_a), .m_eof(eof_a), .busy(busy_a), .done(done_a), .frame_cnt(fcnt_a)
  );

  bicubic_frame_streamer #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .BOTTOM_UP(1), .GAP_PERIOD(3)) u_b (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start_b), .stop(stop_b), .m_ready(ready_b), .m_valid(valid_b), .m_data(data_b),
    .m_eol(eol_b), .m_eof(eof_b), .busy(busy_b), .done(done_b), .frame_cnt(fcnt_b)
  );

  bicubic_frame_streamer #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .NUM_FRAMES(0), .FRAME_GAP(2)) u_c (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start_c), .stop(stop_c), .m_ready(ready_c), .m_valid(valid_c), .m_data(data_c),
    .m_eol(eol_c), .m_eof(eof_c), .busy(busy_c), .done(done_c), .frame_cnt(fcnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt, dn, beats, c11, c12, k;
    bit v, stall;
    logic [23:0] held;

    tick; tick;
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_fcnt", fcnt_a, 0);
    check("rst_done", done_a, 0);
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 12; i++) begin
      ld_en = 1'b1; ld_addr = 4'(i); ld_data = 24'(i);
      tick;
    end
    ld_en = 1'b0;

    // Plain top-down frame at full rate.
    ready_a = 1'b1; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    check("t1_first_cycle_valid", valid_a, 0);
    check("t1_busy", busy_a, 1);
    tick;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      check("t1_valid", valid_a, 1);
      check("t1_data", data_a, 32'(i));
      check("t1_eol", eol_a, 32'(i % 4 == 3));
      check("t1_eof", eof_a, 32'(i == 11));
      dn += int'(done_a);
      tick;
    end
    check("t1_done", done_a, 1);
    dn += int'(done_a);
    check("t1_busy_end", busy_a, 0);
    check("t1_fcnt", fcnt_a, 1);
    check("t1_valid_end", valid_a, 0);
    tick;
    dn += int'(done_a);
    check("t1_done_once", dn, 1);

    // Bottom-up order with one bubble after every third beat.
    ready_b = 1'b1; start_b = 1'b1;
    tick;
    start_b = 1'b0;
    tick;
    for (int c = 0; c < 16; c++) begin
      k = c - c / 4;
      v = (c % 4 != 3);
      check("t4_valid", valid_b, 32'(v));
      if (v) begin
        check("t2_data", data_b, 32'((2 - k / 4) * 4 + k % 4));
        check("t2_eof", eof_b, 32'(k == 11));
      end
      tick;
    end
    check("t2_fcnt", fcnt_b, 1);
    check("t2_busy_end", busy_b, 0);

    // Back-pressure: 1010 toggling, then a 5-cycle stall.
    ready_a = 1'b0; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    nxt = 0; stall = 0; held = '0;
    for (int c = 0; c < 60 && nxt < 12; c++) begin
      if (stall) begin
        check("t3_hold_valid", valid_a, 1);
        check("t3_hold_data", data_a, 32'(held));
      end
      ready_a = (c < 8) ? (c % 2 == 0) : (c >= 13);
      if (valid_a && ready_a) begin
        check("t3_data", data_a, nxt);
        check("t3_eof", eof_a, 32'(nxt == 11));
        nxt++;
      end
      stall = valid_a && !ready_a;
      held = data_a;
      tick;
    end
    check("t3_count", nxt, 12);
    ready_a = 1'b1;
    tick;
    check("t3_valid_end", valid_a, 0);
    check("t3_busy_end", busy_a, 0);
    check("t3_fcnt", fcnt_a, 1);

    // Endless repeat with 2-cycle frame gap, stopped during the second frame.
    ready_c = 1'b1; start_c = 1'b1;
    tick;
    start_c = 1'b0;
    beats = 0; c11 = -1; c12 = -1;
    for (int c = 0; c < 80; c++) begin
      if (done_c) break;
      if (valid_c) begin
        check("t5_data", data_c, 32'(beats % 12));
        check("t5_eof", eof_c, 32'(beats % 12 == 11));
        if (beats == 11) c11 = c;
        if (beats == 12) c12 = c;
        beats++;
      end
      stop_c = (beats == 15);
      tick;
    end
    stop_c = 1'b0;
    check("t5_done", done_c, 1);
    check("t5_beats", beats, 24);
    check("t5_frame_gap", c12 - c11, 3);
    check("t5_fcnt", fcnt_c, 2);
    check("t5_busy_end", busy_c, 0);

    // Reset mid-frame; load and start while busy must be ignored.
    ready_a = 1'b1; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    tick; tick; tick; tick;
    check("t6_mid_data", data_a, 3);
    ld_en = 1'b1; ld_addr = 4'd1; ld_data = 24'h77; start_a = 1'b1;
    tick;
    ld_en = 1'b0; start_a = 1'b0;
    check("t6_busy_start_ignored", data_a, 4);
    check("t6_busy", busy_a, 1);
    rst_n = 1'b0;
    tick;
    check("t6_rst_valid", valid_a, 0);
    check("t6_rst_data", data_a, 0);
    check("t6_rst_eol", eol_a, 0);
    check("t6_rst_eof", eof_a, 0);
    check("t6_rst_busy", busy_a, 0);
    check("t6_rst_done", done_a, 0);
    rst_n = 1'b1;
    ld_en = 1'b1; ld_addr = 4'd0; ld_data = 24'hAA; start_a = 1'b1;
    tick;
    ld_en = 1'b0; start_a = 1'b0;
    check("t6_restart_latency", valid_a, 0);
    tick;
    check("t6_write_before_start", data_a, 32'hAA);
    tick;
    check("t6_busy_write_ignored", data_a, 1);
    tick;
    check("t6_replay", data_a, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
